regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the RV32 core datapath. Supports NREAD combinational read ports and NWRITE write ports, with a hardwired zero register and write-to-read bypass. Includes a busy-bit scoreboard: decode sets a bit per destination at issue, writeback clears it, and read ports report operand readiness. Sits between decode (rs/rd addresses, issue) and writeback (multiple retire lanes).

Parameters:
XLEN, 32, data width in bits.
NREGS, 32, number of architectural registers; power of 2, minimum 2.
NREAD, 2, number of read ports, 1..4.
NWRITE, 1, number of write ports, 1..2.
BYPASS_EN, 1, 1 = same-cycle write data is forwarded to matching reads; 0 = reads return stored value only.
AW, $clog2(NREGS), register address width (derived; not overridden).

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high
rs_addr  in  NREAD*AW  read addresses; port i at bits [i*AW +: AW]
rs_data  out  NREAD*XLEN  read data; port i at bits [i*XLEN +: XLEN]
rs_busy  out  NREAD  port i operand not yet produced
we  in  NWRITE  write enable per port
wr_addr  in  NWRITE*AW  write addresses
wr_data  in  NWRITE*XLEN  write data
issue_valid  in  1  instruction issued this cycle with a destination
issue_rd  in  AW  destination of issued instruction

Behaviour:
- Single clock domain. All state updates on posedge clk. Reset is synchronous and active-high.
- Reset:
  - At the edge where reset=1, all registers are set to 0 and all busy bits to 0.
  - Writes and issues in that cycle are discarded.
  - Reset asserted mid-operation behaves identically; no partial state survives.
- Register 0:
  - Reads always return 0 and rs_busy=0.
  - Writes and issues to address 0 are ignored.
- Reads: combinational; zero-cycle latency from rs_addr.
- Writes:
  - Take effect at the next edge when we[j]=1.
  - If two write ports target the same address in one cycle, the higher-index port wins.
- Bypass (BYPASS_EN=1):
  - If any we[j] with wr_addr[j]==rs_addr[i]!=0, rs_data[i] returns that wr_data; the highest-index matching port wins.
  - rs_busy[i] is forced to 0 in that case.
  - With BYPASS_EN=0, the stored value and stored busy bit are returned; written data is visible the cycle after the write.
- Scoreboard:
  - busy[r] next = set | (busy[r] & ~clear).
  - set = issue_valid & issue_rd==r & r!=0.
  - clear = any we[j] & wr_addr[j]==r.
  - Set and clear on the same register in the same cycle: set wins (the new producer is in flight).
  - Issue to an already busy register: the bit stays 1 (no counting). Writeback alone clears it.
- Reset values:
  - rs_data is 0 for every address after reset.
  - rs_busy is 0 on every port after reset.
- Width rules:
  - Write addresses >= NREGS cannot occur (NREGS is a power of 2).
  - No sign extension or truncation; data is passed through unchanged at XLEN.

Decomposition:
- regfile_pkg:
  - XLEN_DEFAULT and NREGS_DEFAULT constants.
  - reg_addr_t (logic [4:0]) and xword_t (logic [31:0]) typedefs.
  - Function for highest-index write-port match, shared by storage write and bypass.
- Sub-module regfile_scoreboard:
  - Parameters NREGS, NWRITE.
  - Holds the busy vector and set/clear logic.
  - Exports the busy vector to the top level.
  - The top level handles read muxing and bypass override.

Test Plan:
1. Reset then read all 32 addresses on both ports -> rs_data=0, rs_busy=0 for every address.
2. Write x5=0xDEADBEEF via port 0, read rs_addr[0]=5 in the same cycle -> BYPASS_EN=1: 0xDEADBEEF; BYPASS_EN=0: old value 0, then 0xDEADBEEF the next cycle.
3. Write x0=0x12345678 and issue rd=0 -> rs_data for address 0 stays 0, rs_busy stays 0.
4. NWRITE=2: both ports write x7 (port0=0x1, port1=0x2) -> bypassed and stored value is 0x2.
5. Issue rd=9, next cycle read x9 -> rs_busy=1. Writeback x9=0xA5 the cycle after -> rs_busy=0 with data 0xA5 (bypassed). Same-cycle issue rd=9 plus write x9 -> busy=1 on the following cycle.
6. Write x3=0x55 and issue rd=4, assert reset for one cycle -> x3 reads 0, busy[4]=0; a write in the reset cycle is not stored.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types, defaults and the write-port arbitration helper for the
// multi-port integer register file.
package regfile_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  // Widest write-port set the arbitration helper understands.
  localparam int MAX_NWRITE = 4;
  localparam int WSEL_IW    = 2;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] xword_t;

  typedef struct packed {
    logic               found;
    logic [WSEL_IW-1:0] idx;
  } wsel_t;

  // Highest-index asserted hit wins; used by both storage write and bypass.
  function automatic wsel_t hi_match(input logic [MAX_NWRITE-1:0] hits);
    wsel_t s;
    s.found = 1'b0;
    s.idx   = '0;
    for (int j = 0; j < MAX_NWRITE; j++) begin
      s.found = s.found | hits[j];
      s.idx   = hits[j] ? WSEL_IW'(j) : s.idx;
    end
    return s;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: issue marks a destination in flight, any writeback
// to that register clears it; a same-cycle issue takes priority.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int NWRITE = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NWRITE-1:0]    i_we,
  input  logic [NWRITE*AW-1:0] i_wr_addr,
  input  logic                 i_issue_valid,
  input  logic [AW-1:0]        i_issue_rd,
  output logic [NREGS-1:0]     o_busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;

  // Per-register set/clear decode; register 0 can never become busy.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int r = 0; r < NREGS; r++) begin
      w_set[r] = i_issue_valid && (i_issue_rd == AW'(r)) && (r != 0);
      for (int j = 0; j < NWRITE; j++) begin
        w_clr[r] = w_clr[r] | (i_we[j] && (i_wr_addr[j*AW +: AW] == AW'(r)));
      end
    end
  end

  // Busy vector update.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_set | (r_busy & ~w_clr);
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with hardwired x0, optional
// write-to-read bypass and an operand-readiness scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int NREGS     = NREGS_DEFAULT,
  parameter int NREAD     = 2,
  parameter int NWRITE    = 1,
  parameter int BYPASS_EN = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREAD*AW-1:0]    rs_addr,
  output logic [NREAD*XLEN-1:0]  rs_data,
  output logic [NREAD-1:0]       rs_busy,
  input  logic [NWRITE-1:0]      we,
  input  logic [NWRITE*AW-1:0]   wr_addr,
  input  logic [NWRITE*XLEN-1:0] wr_data,
  input  logic                   issue_valid,
  input  logic [AW-1:0]          issue_rd
);

  logic [XLEN-1:0]   r_regs [NREGS];
  logic [NWRITE-1:0] w_whit [NREGS];
  wsel_t             w_wsel [NREGS];
  logic [XLEN-1:0]   w_wdat [NREGS];
  logic [NREGS-1:0]  w_busy;
  logic [AW-1:0]     w_ra;
  logic              w_byp;

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NWRITE (NWRITE)
  ) u_scoreboard (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_we          (we),
    .i_wr_addr     (wr_addr),
    .i_issue_valid (issue_valid),
    .i_issue_rd    (issue_rd),
    .o_busy        (w_busy)
  );

  // Per-register winning write port and its data, shared by store and bypass.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      w_whit[r] = '0;
      for (int j = 0; j < NWRITE; j++) begin
        w_whit[r][j] = we[j] && (wr_addr[j*AW +: AW] == AW'(r));
      end
      w_wsel[r] = hi_match(MAX_NWRITE'(w_whit[r]));
      w_wdat[r] = '0;
      for (int j = 0; j < NWRITE; j++) begin
        w_wdat[r] = (w_wsel[r].found && (int'(w_wsel[r].idx) == j)) ?
                    wr_data[j*XLEN +: XLEN] : w_wdat[r];
      end
    end
  end

  // Storage; x0 is only ever loaded by reset so it always reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        r_regs[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (w_wsel[r].found) begin
          r_regs[r] <= w_wdat[r];
        end
      end
    end
  end

  // Read ports with in-flight write forwarding.
  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    w_ra    = '0;
    w_byp   = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      w_ra  = rs_addr[i*AW +: AW];
      w_byp = (BYPASS_EN != 0) && (w_ra != '0) && w_wsel[w_ra].found;
      rs_data[i*XLEN +: XLEN] = w_byp ? w_wdat[w_ra] : r_regs[w_ra];
      rs_busy[i]              = w_byp ? 1'b0 : w_busy[w_ra];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp built with two write ports and bypass on.
`timescale 1ns/1ps
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rs_addr;
  logic [63:0] rs_data;
  logic [1:0]  rs_busy;
  logic [1:0]  we;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;

  int n_chk  = 0;
  int n_pass = 0;

  regfile_mp #(
    .XLEN      (32),
    .NREGS     (32),
    .NREAD     (2),
    .NWRITE    (2),
    .BYPASS_EN (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rs_addr     (rs_addr),
    .rs_data     (rs_data),
    .rs_busy     (rs_busy),
    .we          (we),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we          = 2'b00;
    issue_valid = 1'b0;
  endtask

  task automatic setr(input int p, input logic [4:0] a);
    rs_addr[p*5 +: 5] = a;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    we[p]              = 1'b1;
    wr_addr[p*5 +: 5]  = a;
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic issue(input logic [4:0] a);
    issue_valid = 1'b1;
    issue_rd    = a;
  endtask

  initial begin
    reset = 1'b1; rs_addr = '0; we = '0; wr_addr = '0; wr_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    tick(); tick();
    reset = 1'b0;

    // 1. every register zero and idle after reset
    for (int a = 0; a < 32; a++) begin
      setr(0, 5'(a)); setr(1, 5'(a)); #1;
      chk($sformatf("rst_d0_x%0d", a), rs_data[31:0], 32'h0);
      chk($sformatf("rst_d1_x%0d", a), rs_data[63:32], 32'h0);
      chk($sformatf("rst_b_x%0d", a), {30'h0, rs_busy}, 32'h0);
    end

    // 2. same-cycle bypass then stored value
    wr(0, 5'd5, 32'hDEADBEEF); setr(0, 5'd5); setr(1, 5'd6); #1;
    chk("byp_x5", rs_data[31:0], 32'hDEADBEEF);
    chk("byp_x5_busy", {31'h0, rs_busy[0]}, 32'h0);
    chk("nobyp_x6", rs_data[63:32], 32'h0);
    tick(); idle(); #1;
    chk("st_x5", rs_data[31:0], 32'hDEADBEEF);

    // 3. x0 ignores writes and issues
    wr(0, 5'd0, 32'h12345678); wr(1, 5'd0, 32'h87654321); issue(5'd0);
    setr(0, 5'd0); setr(1, 5'd0); #1;
    chk("x0_byp", rs_data[31:0], 32'h0);
    chk("x0_busy_now", {30'h0, rs_busy}, 32'h0);
    tick(); idle(); #1;
    chk("x0_st", rs_data[63:32], 32'h0);
    chk("x0_busy_after", {30'h0, rs_busy}, 32'h0);

    // 4. two ports to one address: port 1 wins
    wr(0, 5'd7, 32'h1); wr(1, 5'd7, 32'h2); setr(0, 5'd7); setr(1, 5'd7); #1;
    chk("dual_byp", rs_data[63:32], 32'h2);
    tick(); idle(); #1;
    chk("dual_st", rs_data[31:0], 32'h2);
    wr(0, 5'd8, 32'hAAAA5555); wr(1, 5'd13, 32'h1313); setr(1, 5'd8); setr(0, 5'd13); #1;
    chk("p0_byp", rs_data[63:32], 32'hAAAA5555);
    chk("p1_byp", rs_data[31:0], 32'h1313);
    tick(); idle(); #1;
    chk("p0_st", rs_data[63:32], 32'hAAAA5555);

    // 5. scoreboard set / clear / priority
    setr(0, 5'd9); setr(1, 5'd5); issue(5'd9); #1;
    chk("sb_pre", {31'h0, rs_busy[0]}, 32'h0);
    tick(); idle(); #1;
    chk("sb_set", {31'h0, rs_busy[0]}, 32'h1);
    chk("sb_other", {31'h0, rs_busy[1]}, 32'h0);
    wr(1, 5'd9, 32'hA5); #1;
    chk("sb_wb_busy", {31'h0, rs_busy[0]}, 32'h0);
    chk("sb_wb_data", rs_data[31:0], 32'hA5);
    tick(); idle(); #1;
    chk("sb_clr", {31'h0, rs_busy[0]}, 32'h0);
    chk("sb_clr_data", rs_data[31:0], 32'hA5);
    issue(5'd9); wr(0, 5'd9, 32'h5A); #1;
    chk("sb_same_byp", rs_data[31:0], 32'h5A);
    chk("sb_same_bz", {31'h0, rs_busy[0]}, 32'h0);
    tick(); idle(); #1;
    chk("sb_set_wins", {31'h0, rs_busy[0]}, 32'h1);
    chk("sb_set_data", rs_data[31:0], 32'h5A);
    issue(5'd9); wr(0, 5'd12, 32'hC); tick(); idle(); tick(); #1;
    chk("sb_reissue", {31'h0, rs_busy[0]}, 32'h1);
    wr(1, 5'd9, 32'hC3); tick(); idle(); #1;
    chk("sb_clr2", {31'h0, rs_busy[0]}, 32'h0);
    chk("sb_clr2_data", rs_data[31:0], 32'hC3);

    // 6. reset mid-operation wipes everything, reset-cycle writes dropped
    wr(0, 5'd3, 32'h55); issue(5'd4); tick(); idle();
    setr(0, 5'd3); setr(1, 5'd4); #1;
    chk("pre_rst_x3", rs_data[31:0], 32'h55);
    chk("pre_rst_b4", {31'h0, rs_busy[1]}, 32'h1);
    reset = 1'b1; wr(0, 5'd3, 32'h77); wr(1, 5'd11, 32'h99); issue(5'd10);
    tick(); reset = 1'b0; idle(); #1;
    chk("rst_x3", rs_data[31:0], 32'h0);
    chk("rst_b4", {31'h0, rs_busy[1]}, 32'h0);
    setr(0, 5'd11); setr(1, 5'd10); #1;
    chk("rst_x11", rs_data[31:0], 32'h0);
    chk("rst_b10", {31'h0, rs_busy[1]}, 32'h0);
    chk("rst_x10", rs_data[63:32], 32'h0);
    setr(0, 5'd5); #1;
    chk("rst_x5", rs_data[31:0], 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
